// File: rtl/conv_frame_sched_if.sv
// conv_frame_sched_if
//   Bundles the control and pixel-stream signals around the frame sequencer.
//   master : the sequencer. It consumes start/abort/src_rdy and drives the
//            layer-side strobes, the pixel fetch address, the output-window
//            tags and the status flags.
//   slave  : the host/pixel-source side, which is the mirror image.
//   Signals:
//     start, abort, src_rdy        host/source -> sequencer
//     start_wr, start_rd, de       sequencer -> conv_layer
//     rd_en, rd_addr               sequencer -> pixel source
//     out_valid, out_row, out_col  tags for the conv result at the layer output
//     busy, done, err              status
interface conv_frame_sched_if #(
  parameter int ADDR_W = 16
) ();
  logic              start;
  logic              abort;
  logic              src_rdy;
  logic              start_wr;
  logic              start_rd;
  logic              de;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              out_valid;
  logic [9:0]        out_row;
  logic [5:0]        out_col;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, abort, src_rdy,
    output start_wr, start_rd, de, rd_en, rd_addr,
    output out_valid, out_row, out_col, busy, done, err
  );

  modport slave (
    output start, abort, src_rdy,
    input  start_wr, start_rd, de, rd_en, rd_addr,
    input  out_valid, out_row, out_col, busy, done, err
  );
endinterface

// File: rtl/conv_frame_sched.sv
// conv_frame_sched
//   Frame-level sequencer for the 3x3 convolution layer. For each accepted
//   start it holds start_rd while the layer fetches its weights, then streams
//   IMG_H rows of IMG_W pixels as de bursts (each row waits for src_rdy),
//   flushes the layer pipeline and pulses done. A delay line matching the
//   layer latency tags each result that came from a full 3x3 window.
//   Ports:
//     clk    system clock, rising edge
//     RESET  asynchronous, active-low reset
//     bus    conv_frame_sched_if.master (see the interface for signal roles)
module conv_frame_sched #(
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32,
  parameter int WLOAD_CYC = 18,
  parameter int GAP_CYC   = 4,
  parameter int OUT_LAT   = 7,
  parameter int ADDR_W    = 16
) (
  input  logic               clk,
  input  logic               RESET,
  conv_frame_sched_if.master bus
);

  // One shared phase counter serves WLOAD, GAP and FLUSH.
  localparam int CNT_A   = (WLOAD_CYC > GAP_CYC) ? WLOAD_CYC : GAP_CYC;
  localparam int CNT_MAX = (CNT_A > OUT_LAT + 1) ? CNT_A : OUT_LAT + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_WAIT,
    S_ROW,
    S_GAP,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [9:0]        row_q, row_d;
  logic [5:0]        col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  logic              de;
  logic              start_wr;
  logic              start_rd;
  logic              busy;
  logic              done;

  // Delay line aligning (de, row, col) with the layer output.
  logic              vld_dly_q [OUT_LAT];
  logic              vld_dly_d [OUT_LAT];
  logic [9:0]        row_dly_q [OUT_LAT];
  logic [9:0]        row_dly_d [OUT_LAT];
  logic [5:0]        col_dly_q [OUT_LAT];
  logic [5:0]        col_dly_d [OUT_LAT];

  logic              out_valid;

  // A result is usable only once two earlier rows and columns exist.
  function automatic logic win_ok(input logic [9:0] r, input logic [5:0] c);
    return (r >= 10'd2) && (c >= 6'd2);
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    addr_d   = addr_q;
    err_d    = err_q;
    de       = 1'b0;
    start_wr = 1'b0;
    start_rd = 1'b0;
    busy     = (state_q != S_IDLE);
    done     = 1'b0;

    // A start outside IDLE is dropped but remembered in the sticky flag.
    if (bus.start && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_WLOAD;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
          err_d   = 1'b0;
        end
      end

      S_WLOAD: begin
        start_rd = 1'b1;
        if (cnt_q == CNT_W'(WLOAD_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT: begin
        start_wr = 1'b1;
        if (bus.src_rdy) begin
          state_d = S_ROW;
        end
      end

      S_ROW: begin
        // src_rdy is deliberately ignored here: a row is never split.
        start_wr = 1'b1;
        de       = 1'b1;
        addr_d   = addr_q + ADDR_W'(1);
        if (col_q == 6'(IMG_W - 1)) begin
          col_d = '0;
          cnt_d = '0;
          if (row_q == 10'(IMG_H - 1)) begin
            // Park the address and row at zero instead of running past the frame.
            row_d   = '0;
            addr_d  = '0;
            state_d = S_FLUSH;
          end else begin
            row_d   = row_q + 10'd1;
            state_d = S_GAP;
          end
        end else begin
          col_d = col_q + 6'd1;
        end
      end

      S_GAP: begin
        start_wr = 1'b1;
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FLUSH: begin
        // start_wr stays high so the layer's row ping-pong does not advance.
        start_wr = 1'b1;
        if (cnt_q == CNT_W'(OUT_LAT)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a same-cycle start.
    if (bus.abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      row_d   = '0;
      col_d   = '0;
      addr_d  = '0;
      err_d   = err_q;
    end
  end

  always_comb begin
    vld_dly_d[0] = de;
    row_dly_d[0] = row_q;
    col_dly_d[0] = col_q;
    for (int i = 1; i < OUT_LAT; i++) begin
      vld_dly_d[i] = vld_dly_q[i-1];
      row_dly_d[i] = row_dly_q[i-1];
      col_dly_d[i] = col_dly_q[i-1];
    end
    if (bus.abort) begin
      for (int i = 0; i < OUT_LAT; i++) begin
        vld_dly_d[i] = 1'b0;
        row_dly_d[i] = '0;
        col_dly_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < OUT_LAT; i++) begin
        vld_dly_q[i] <= 1'b0;
        row_dly_q[i] <= '0;
        col_dly_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      vld_dly_q <= vld_dly_d;
      row_dly_q <= row_dly_d;
      col_dly_q <= col_dly_d;
    end
  end

  assign out_valid = vld_dly_q[OUT_LAT-1] &&
                     win_ok(row_dly_q[OUT_LAT-1], col_dly_q[OUT_LAT-1]);

  assign bus.start_wr  = start_wr;
  assign bus.start_rd  = start_rd;
  assign bus.de        = de;
  assign bus.rd_en     = de;
  assign bus.rd_addr   = de ? addr_q : '0;
  assign bus.out_valid = out_valid;
  assign bus.out_row   = out_valid ? (row_dly_q[OUT_LAT-1] - 10'd2) : '0;
  assign bus.out_col   = out_valid ? (col_dly_q[OUT_LAT-1] - 6'd2) : '0;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_conv_frame_sched.sv
// tb_conv_frame_sched
//   Two sequencers share one clock: dut0 (8x4 frame) walks through the
//   directed scenarios, dut1 (default 32x32) runs one frame under random
//   src_rdy. Before simulation the bench lays out every input per cycle and
//   builds the expected per-cycle outputs from the frame timeline rules.
module tb_conv_frame_sched;
  localparam int N     = 4096;
  localparam int WLOAD = 18;
  localparam int GAP   = 4;
  localparam int LAT   = 7;

  typedef struct packed {
    logic        sw;
    logic        sr;
    logic        de;
    logic        re;
    logic [15:0] addr;
    logic        ov;
    logic [9:0]  orow;
    logic [5:0]  ocol;
    logic        busy;
    logic        done;
    logic        err;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n0;
  logic rst_n1;
  always #5 clk = ~clk;

  conv_frame_sched_if #(.ADDR_W(16)) ifc0 ();
  conv_frame_sched_if #(.ADDR_W(16)) ifc1 ();

  conv_frame_sched #(.IMG_W(8), .IMG_H(4)) dut0 (
    .clk   (clk),
    .RESET (rst_n0),
    .bus   (ifc0.master)
  );

  conv_frame_sched dut1 (
    .clk   (clk),
    .RESET (rst_n1),
    .bus   (ifc1.master)
  );

  obs_t expv [2][N];
  obs_t actv [2][N];
  bit   src  [2][N];
  bit   st   [2][N];
  bit   ab   [2][N];
  bit   rsn  [2][N];

  int nchk  = 0;
  int nfail = 0;
  int cyc   = 0;
  bit running = 1'b0;

  // Expected outputs of one frame started by a start pulse in cycle ts.
  task automatic build(input int d, input int w, input int h, input int ts,
                       output int tend, output int tfl);
    int t;
    t = ts + 1;
    for (int k = 0; k < WLOAD; k++) begin
      expv[d][t].sr = 1'b1; expv[d][t].busy = 1'b1; t++;
    end
    for (int r = 0; r < h; r++) begin
      // wait for a ready source; the row begins the cycle after it is seen
      do begin
        expv[d][t].sw = 1'b1; expv[d][t].busy = 1'b1; t++;
      end while (!src[d][t-1] && t < N - 200);
      for (int c = 0; c < w; c++) begin
        expv[d][t].sw = 1'b1; expv[d][t].busy = 1'b1;
        expv[d][t].de = 1'b1; expv[d][t].re = 1'b1;
        expv[d][t].addr = 16'(r * w + c);
        if (r >= 2 && c >= 2) begin
          expv[d][t+LAT].ov   = 1'b1;
          expv[d][t+LAT].orow = 10'(r - 2);
          expv[d][t+LAT].ocol = 6'(c - 2);
        end
        t++;
      end
      if (r < h - 1) begin
        for (int k = 0; k < GAP; k++) begin
          expv[d][t].sw = 1'b1; expv[d][t].busy = 1'b1; t++;
        end
      end
    end
    tfl = t;
    for (int k = 0; k < LAT + 1; k++) begin
      expv[d][t].sw = 1'b1; expv[d][t].busy = 1'b1; t++;
    end
    expv[d][t].done = 1'b1; expv[d][t].busy = 1'b1; t++;
    tend = t;
  endtask

  task automatic zero_out(input int d, input int a, input int b);
    for (int t = a; t < b; t++) expv[d][t] = '0;
  endtask

  task automatic drive(input int c);
    ifc0.start   = st[0][c];
    ifc0.abort   = ab[0][c];
    ifc0.src_rdy = src[0][c];
    rst_n0       = rsn[0][c];
    ifc1.start   = st[1][c];
    ifc1.abort   = ab[1][c];
    ifc1.src_rdy = src[1][c];
    rst_n1       = rsn[1][c];
  endtask

  task automatic chk(input string nm, input longint got, input longint want);
    nchk++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  // Count DUT cycles in [a,b) where the chosen output was high.
  function automatic int cnt(input int d, input int f, input int a, input int b);
    int n;
    n = 0;
    for (int t = a; t < b; t++) begin
      case (f)
        0: n += int'(actv[d][t].sr);
        1: n += int'(actv[d][t].de);
        2: n += int'(actv[d][t].ov);
        3: n += int'(actv[d][t].done);
        default: n += int'(actv[d][t].busy);
      endcase
    end
    return n;
  endfunction

  always @(negedge clk) begin
    if (running) begin
      obs_t a0, a1;
      a0 = {ifc0.start_wr, ifc0.start_rd, ifc0.de, ifc0.rd_en, ifc0.rd_addr,
            ifc0.out_valid, ifc0.out_row, ifc0.out_col, ifc0.busy, ifc0.done, ifc0.err};
      a1 = {ifc1.start_wr, ifc1.start_rd, ifc1.de, ifc1.rd_en, ifc1.rd_addr,
            ifc1.out_valid, ifc1.out_row, ifc1.out_col, ifc1.busy, ifc1.done, ifc1.err};
      actv[0][cyc] = a0;
      actv[1][cyc] = a1;
      nchk += 2;
      if (a0 !== expv[0][cyc]) begin
        nfail++;
        $display("FAIL dut0_cycle %0d: got %h, expected %h", cyc, a0, expv[0][cyc]);
      end
      if (a1 !== expv[1][cyc]) begin
        nfail++;
        $display("FAIL dut1_cycle %0d: got %h, expected %h", cyc, a1, expv[1][cyc]);
      end
    end
  end

  initial begin
    int tsA, eA, tsB, eB, tsC, eC, tsD, eD, tsE, eE, tsF, eF, flF, tsG, eG;
    int ts1, e1, fl, endsim, tr, n_exp, bad, nov;
    logic cur;
    int hits [32][32];

    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < N; t++) begin
        src[d][t] = (d == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        st[d][t]  = 1'b0;
        ab[d][t]  = 1'b0;
        rsn[d][t] = (t >= 4);
        expv[d][t] = '0;
        actv[d][t] = '0;
      end
    end

    // dut0 directed schedule
    tsA = 6;             st[0][tsA] = 1'b1; build(0, 8, 4, tsA, eA, fl);
    tsB = eA + 3;        st[0][tsB] = 1'b1;
    for (int t = tsB + 41; t <= tsB + 50; t++) src[0][t] = 1'b0;
    build(0, 8, 4, tsB, eB, fl);
    tsC = eB + 3;        st[0][tsC] = 1'b1; st[0][tsC+25] = 1'b1;
    build(0, 8, 4, tsC, eC, fl);
    tsD = eC + 3;        st[0][tsD] = 1'b1; build(0, 8, 4, tsD, eD, fl);
    ab[0][tsD+23] = 1'b1; zero_out(0, tsD + 24, eD);
    tsE = tsD + 27;      st[0][tsE] = 1'b1; build(0, 8, 4, tsE, eE, fl);
    tsF = eE + 3;        st[0][tsF] = 1'b1; build(0, 8, 4, tsF, eF, flF);
    tr = flF + 3;
    for (int t = tr; t < tr + 3; t++) rsn[0][t] = 1'b0;
    zero_out(0, tr, eF);
    tsG = eF + 3;        st[0][tsG] = 1'b1; build(0, 8, 4, tsG, eG, fl);

    // dut1: one default-size frame under random src_rdy
    ts1 = 8;             st[1][ts1] = 1'b1; build(1, 32, 32, ts1, e1, fl);

    endsim = ((eG > e1) ? eG : e1) + 10;

    // sticky err: set by a start seen while busy, cleared by an accepted start
    for (int d = 0; d < 2; d++) begin
      cur = 1'b0;
      for (int t = 0; t < N; t++) begin
        if (!rsn[d][t]) cur = 1'b0;
        expv[d][t].err = cur;
        if (rsn[d][t] && !ab[d][t] && st[d][t]) cur = expv[d][t].busy;
      end
    end

    cyc = 0;
    drive(0);
    running = 1'b1;
    while (cyc < endsim - 1) begin
      @(posedge clk);
      cyc++;
      #1 drive(cyc);
    end
    @(negedge clk);
    #2 running = 1'b0;

    // reset state
    chk("reset_dut0", longint'(actv[0][1]), 0);
    chk("reset_dut1", longint'(actv[1][1]), 0);
    // basic frame
    chk("t1_start_rd_cycles", cnt(0, 0, tsA, eA), 18);
    chk("t1_de_cycles", cnt(0, 1, tsA, eA), 32);
    chk("t1_out_valid", cnt(0, 2, tsA, eA), 12);
    chk("t1_done", cnt(0, 3, tsA, eA), 1);
    chk("t1_busy_after", actv[0][eA].busy, 0);
    n_exp = 0;
    for (int t = tsA; t < eA; t++) n_exp += int'(expv[0][t].ov);
    chk("t1_model_out_valid", n_exp, 12);
    // source stall
    chk("t2_wait_de", actv[0][tsB+51].de, 0);
    chk("t2_wait_start_wr", actv[0][tsB+51].sw, 1);
    chk("t2_resume_de", actv[0][tsB+52].de, 1);
    chk("t2_resume_addr", actv[0][tsB+52].addr, 16);
    // start while busy
    chk("t3_err_set", actv[0][tsC+26].err, 1);
    chk("t3_err_held", actv[0][tsD].err, 1);
    chk("t3_err_clear", actv[0][tsD+1].err, 0);
    chk("t3_done", cnt(0, 3, tsC, eC), 1);
    // abort
    chk("t4_col3_addr", actv[0][tsD+23].addr, 3);
    chk("t4_after_abort", longint'(actv[0][tsD+24]), 0);
    chk("t4_no_done", cnt(0, 3, tsD, tsE), 0);
    chk("t4_rerun_ov", cnt(0, 2, tsE, eE), 12);
    chk("t4_rerun_done", cnt(0, 3, tsE, eE), 1);
    // reset mid-flush
    chk("t5_in_flush", actv[0][tr-1].sw, 1);
    chk("t5_reset_zero", longint'(actv[0][tr]), 0);
    chk("t5_idle_busy", cnt(0, 4, tr, tsG + 1), 0);
    chk("t5_no_done", cnt(0, 3, tsF, tsG), 0);
    chk("t5_rerun_done", cnt(0, 3, tsG, eG), 1);
    // default-size coverage
    for (int r = 0; r < 32; r++) for (int c = 0; c < 32; c++) hits[r][c] = 0;
    nov = 0;
    bad = 0;
    for (int t = 0; t < endsim; t++) begin
      if (actv[1][t].ov) begin
        nov++;
        if (actv[1][t].orow < 10'd32) hits[actv[1][t].orow][actv[1][t].ocol[4:0]]++;
        else bad++;
        if (actv[1][t].ocol >= 6'd32) bad++;
      end
    end
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        if ((r < 30 && c < 30) ? (hits[r][c] != 1) : (hits[r][c] != 0)) bad++;
    chk("t6_out_valid", nov, 900);
    chk("t6_cover_once", bad, 0);
    chk("t6_done", cnt(1, 3, ts1, e1), 1);
    n_exp = 0;
    for (int t = 0; t < N; t++) n_exp += int'(expv[1][t].ov);
    chk("t6_model_out_valid", n_exp, 900);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule
